// File: rtl/row_by_vector_pipelined_accumulator.sv
// Chunked row-by-vector dot product: lane-wise multiply, registered adder tree,
// cross-chunk accumulation and a result FIFO with credit-based input back-pressure.
module row_by_vector_pipelined_accumulator #(
   parameter int unsigned NI            = 8,
   parameter int unsigned element_width = 32,
   parameter int unsigned ACC_W         = 80,
   parameter int unsigned RES_DEPTH     = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NI*element_width-1:0]   a,
   input  logic [NI*element_width-1:0]   p,
   input  logic                          start_row_by_vector,
   output logic                          prepare_my_new_input,
   input  logic [31:0]                   no_of_multiples,
   input  logic                          signed_mode,
   output logic                          give_me_only,
   output logic [ACC_W-1:0]              result,
   output logic                          decoder_read_now,
   input  logic                          you_can_read
);

   localparam int unsigned W     = element_width;
   localparam int unsigned LG    = $clog2(NI);
   localparam int unsigned PW    = 2 * W;
   localparam int unsigned SW    = PW + LG;
   localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);

   // chunk / row bookkeeping
   logic [31:0]       chunk_cnt_q, chunk_cnt_d;
   logic [31:0]       row_len_q, row_len_d;
   logic [31:0]       len_new_c, eff_len_c;
   logic              first_c, last_c, accept_c, pop_c;
   logic [CNT_W-1:0]  rows_pending_q, rows_pending_d;
   logic              give_q, give_d;

   // datapath pipe: index 0 = product stage, index l+1 = tree level l
   logic [PW-1:0]     prod_q [NI];
   logic [PW-1:0]     prod_d [NI];
   logic [SW-1:0]     lvl_q  [LG][NI];
   logic [SW-1:0]     lvl_d  [LG][NI];
   logic [LG:0]       vld_q, vld_d, first_q, first_d, last_q, last_d, sgn_q, sgn_d;
   logic [ACC_W-1:0]  tsum_c;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              wr_q, wr_d;

   // result FIFO
   logic [ACC_W-1:0]  mem_q [RES_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

   function automatic logic [SW-1:0] ext_prod(input logic [PW-1:0] x, input logic s);
      return {{(SW-PW){s & x[PW-1]}}, x};
   endfunction

   function automatic logic [ACC_W-1:0] ext_sum(input logic [SW-1:0] x, input logic s);
      logic [ACC_W-1:0] r;
      r          = {ACC_W{s & x[SW-1]}};
      r[SW-1:0]  = x;
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] x);
      return (x == PTR_W'(RES_DEPTH - 1)) ? '0 : x + PTR_W'(1);
   endfunction

   // A started row always completes; a new row waits for a guaranteed FIFO slot
   assign prepare_my_new_input = (rows_pending_q < CNT_W'(RES_DEPTH)) || (chunk_cnt_q != 32'd0);
   assign decoder_read_now     = (fifo_cnt_q != '0);
   assign result               = mem_q[rd_ptr_q];
   assign give_me_only         = give_q;

   always_comb begin : ctrl_comb
      len_new_c      = (no_of_multiples == 32'd0) ? 32'd1 : no_of_multiples;
      eff_len_c      = (chunk_cnt_q == 32'd0) ? len_new_c : row_len_q;
      first_c        = (chunk_cnt_q == 32'd0);
      last_c         = (chunk_cnt_q == eff_len_c - 32'd1);
      accept_c       = start_row_by_vector && prepare_my_new_input;
      pop_c          = decoder_read_now && you_can_read;
      chunk_cnt_d    = chunk_cnt_q;
      row_len_d      = row_len_q;
      if (accept_c) begin
         row_len_d   = eff_len_c;
         chunk_cnt_d = last_c ? 32'd0 : chunk_cnt_q + 32'd1;
      end
      rows_pending_d = rows_pending_q + CNT_W'(accept_c && last_c) - CNT_W'(pop_c);
      give_d         = accept_c && last_c;
   end

   always_comb begin : pipe_comb
      for (int k = 0; k < NI; k++) begin
         prod_d[k] = {{W{signed_mode & a[k*W+W-1]}}, a[k*W +: W]}
                   * {{W{signed_mode & p[k*W+W-1]}}, p[k*W +: W]};
      end
      vld_d   = {vld_q[LG-1:0], accept_c};
      first_d = {first_q[LG-1:0], first_c};
      last_d  = {last_q[LG-1:0], last_c};
      sgn_d   = {sgn_q[LG-1:0], signed_mode};
      for (int l = 0; l < LG; l++) begin
         for (int i = 0; i < NI; i++) begin
            lvl_d[l][i] = '0;
         end
      end
      for (int i = 0; i < NI / 2; i++) begin
         lvl_d[0][i] = ext_prod(prod_q[2*i], sgn_q[0]) + ext_prod(prod_q[2*i+1], sgn_q[0]);
      end
      for (int l = 1; l < LG; l++) begin
         for (int i = 0; i < (NI >> (l + 1)); i++) begin
            lvl_d[l][i] = lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
         end
      end
      tsum_c = ext_sum(lvl_q[LG-1][0], sgn_q[LG]);
      acc_d  = acc_q;
      if (vld_q[LG]) begin
         acc_d = first_q[LG] ? tsum_c : acc_q + tsum_c;
      end
      wr_d       = vld_q[LG] & last_q[LG];
      wr_ptr_d   = wr_q  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_q) - CNT_W'(pop_c);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chunk_cnt_q    <= '0;
         row_len_q      <= '0;
         rows_pending_q <= '0;
         give_q         <= 1'b0;
         vld_q          <= '0;
         first_q        <= '0;
         last_q         <= '0;
         sgn_q          <= '0;
         acc_q          <= '0;
         wr_q           <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fifo_cnt_q     <= '0;
         for (int k = 0; k < NI; k++) begin
            prod_q[k] <= '0;
         end
         for (int l = 0; l < LG; l++) begin
            for (int i = 0; i < NI; i++) begin
               lvl_q[l][i] <= '0;
            end
         end
         for (int i = 0; i < RES_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         chunk_cnt_q    <= chunk_cnt_d;
         row_len_q      <= row_len_d;
         rows_pending_q <= rows_pending_d;
         give_q         <= give_d;
         vld_q          <= vld_d;
         first_q        <= first_d;
         last_q         <= last_d;
         sgn_q          <= sgn_d;
         acc_q          <= acc_d;
         wr_q           <= wr_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fifo_cnt_q     <= fifo_cnt_d;
         prod_q         <= prod_d;
         lvl_q          <= lvl_d;
         // acc_q still holds the finished row here even if a new row loads this edge
         if (wr_q) begin
            mem_q[wr_ptr_q] <= acc_q;
         end
      end
   end

endmodule

// File: tb/tb_row_by_vector_pipelined_accumulator.sv
// Self-checking bench: directed scenarios plus randomized rows checked against
// an arithmetic dot-product model and an expected-result queue.
module tb_row_by_vector_pipelined_accumulator;

   localparam int unsigned NI    = 8;
   localparam int unsigned W     = 32;
   localparam int unsigned AW    = 80;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned VW    = NI * W;

   logic          clk;
   logic          reset;
   logic [VW-1:0] a, p;
   logic          start_row_by_vector;
   logic          prepare_my_new_input;
   logic [31:0]   no_of_multiples;
   logic          signed_mode;
   logic          give_me_only;
   logic [AW-1:0] result;
   logic          decoder_read_now;
   logic          you_can_read;

   int n_checks = 0;
   int n_fail   = 0;

   row_by_vector_pipelined_accumulator #(
      .NI(NI), .element_width(W), .ACC_W(AW), .RES_DEPTH(DEPTH)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .a                    (a),
      .p                    (p),
      .start_row_by_vector  (start_row_by_vector),
      .prepare_my_new_input (prepare_my_new_input),
      .no_of_multiples      (no_of_multiples),
      .signed_mode          (signed_mode),
      .give_me_only         (give_me_only),
      .result               (result),
      .decoder_read_now     (decoder_read_now),
      .you_can_read         (you_can_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Dot product of one chunk, modulo 2^AW, with operands extended to AW bits
   function automatic logic [AW-1:0] model_chunk(input logic [VW-1:0] av, input logic [VW-1:0] pv,
                                                 input logic s);
      logic [AW-1:0] t, x, y;
      t = '0;
      for (int k = 0; k < NI; k++) begin
         x = {{(AW-W){s & av[k*W+W-1]}}, av[k*W +: W]};
         y = {{(AW-W){s & pv[k*W+W-1]}}, pv[k*W +: W]};
         t = t + x * y;
      end
      return t;
   endfunction

   function automatic logic [VW-1:0] fill_vec(input logic [W-1:0] val);
      logic [VW-1:0] v;
      for (int k = 0; k < NI; k++) v[k*W +: W] = val;
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < NI; k++) v[k*W +: W] = W'($urandom());
      return v;
   endfunction

   // Present a chunk at a negedge, wait for ready, return at the negedge after acceptance
   task automatic send_chunk(input logic [VW-1:0] av, input logic [VW-1:0] pv,
                             input logic [31:0] nm, input logic s);
      bit ok;
      a = av; p = pv; no_of_multiples = nm; signed_mode = s;
      start_row_by_vector = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (prepare_my_new_input) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: ready=%0b, required 1 within 300 cycles", prepare_my_new_input);
      end
      @(negedge clk);
      start_row_by_vector = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start_row_by_vector = 1'b0; you_can_read = 1'b0;
      a = '0; p = '0; no_of_multiples = 32'd1; signed_mode = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (prepare_my_new_input !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", prepare_my_new_input); end
      n_checks++; if (give_me_only !== 1'b0) begin n_fail++; $display("FAIL reset_give: got %0b required 0", give_me_only); end
      n_checks++; if (decoder_read_now !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", decoder_read_now); end
      n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %0h required 0", result); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_chunk();
      logic [VW-1:0] av, pv;
      for (int k = 0; k < NI; k++) av[k*W +: W] = W'(k + 1);
      pv = fill_vec(W'(2));
      you_can_read = 1'b1;
      send_chunk(av, pv, 32'd1, 1'b0);
      n_checks++; if (give_me_only !== 1'b1) begin n_fail++; $display("FAIL single_give_t1: got %0b required 1", give_me_only); end
      @(negedge clk);
      n_checks++; if (give_me_only !== 1'b0) begin n_fail++; $display("FAIL single_give_t2: got %0b required 0", give_me_only); end
      repeat (3) @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %0b required 0 at T+5", decoder_read_now); end
      @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b1) begin n_fail++; $display("FAIL single_valid_t6: got %0b required 1", decoder_read_now); end
      n_checks++; if (result !== AW'(72)) begin n_fail++; $display("FAIL single_result: got %0d required 72", result); end
      @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b0) begin n_fail++; $display("FAIL single_valid_after_pop: got %0b required 0", decoder_read_now); end
   endtask

   task automatic test_signed_multi();
      logic [VW-1:0] av, pv;
      logic [AW-1:0] exp_v;
      int pops;
      av = fill_vec('1); pv = fill_vec(W'(5));
      exp_v = '0;
      you_can_read = 1'b1;
      for (int c = 0; c < 3; c++) begin
         exp_v = exp_v + model_chunk(av, pv, 1'b1);
         send_chunk(av, pv, 32'd3, 1'b1);
         n_checks++;
         if (give_me_only !== (c == 2)) begin n_fail++; $display("FAIL signed_give_chunk%0d: got %0b required %0b", c, give_me_only, (c == 2)); end
      end
      pops = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (decoder_read_now && you_can_read) begin
            pops++;
            n_checks++; if (result !== exp_v) begin n_fail++; $display("FAIL signed_result: got %0h required %0h", result, exp_v); end
         end
      end
      n_checks++; if (pops != 1) begin n_fail++; $display("FAIL signed_writes: got %0d results required 1", pops); end
   endtask

   task automatic test_back_pressure();
      logic [VW-1:0] av [4];
      logic [VW-1:0] pv;
      logic [AW-1:0] exp_v [4];
      int got;
      pv = '0; pv[W-1:0] = W'(1);
      for (int i = 0; i < 4; i++) begin
         av[i] = '0; av[i][W-1:0] = W'(10 * (i + 1));
         exp_v[i] = AW'(10 * (i + 1));
      end
      you_can_read = 1'b0;
      send_chunk(av[0], pv, 32'd1, 1'b0);
      send_chunk(av[1], pv, 32'd1, 1'b0);
      n_checks++; if (prepare_my_new_input !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %0b required 0", prepare_my_new_input); end
      a = av[2]; start_row_by_vector = 1'b1;
      repeat (8) @(negedge clk);
      n_checks++; if (prepare_my_new_input !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %0b required 0", prepare_my_new_input); end
      n_checks++; if (decoder_read_now !== 1'b1 || result !== exp_v[0]) begin n_fail++; $display("FAIL bp_head: valid %0b result %0d required 1 / %0d", decoder_read_now, result, exp_v[0]); end
      got = 0;
      fork
         begin
            send_chunk(av[2], pv, 32'd1, 1'b0);
            send_chunk(av[3], pv, 32'd1, 1'b0);
         end
         begin
            you_can_read = 1'b1;
            for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
               if (decoder_read_now) begin
                  n_checks++; if (result !== exp_v[got]) begin n_fail++; $display("FAIL bp_order%0d: got %0d required %0d", got, result, exp_v[got]); end
                  got++;
               end
               @(negedge clk);
            end
         end
      join
      n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d results required 4", got); end
   endtask

   task automatic test_length_rules();
      logic [VW-1:0] av, pv;
      logic [AW-1:0] exp_v [2];
      int got;
      you_can_read = 1'b0;
      av = rand_vec(); pv = rand_vec();
      exp_v[0] = model_chunk(av, pv, 1'b0);
      send_chunk(av, pv, 32'd0, 1'b0);
      n_checks++; if (give_me_only !== 1'b1) begin n_fail++; $display("FAIL len_zero_give: got %0b required 1", give_me_only); end
      exp_v[1] = '0;
      for (int c = 0; c < 4; c++) begin
         av = rand_vec(); pv = rand_vec();
         exp_v[1] = exp_v[1] + model_chunk(av, pv, 1'b1);
         send_chunk(av, pv, (c == 0) ? 32'd4 : 32'd2, 1'b1);
         n_checks++;
         if (give_me_only !== (c == 3)) begin n_fail++; $display("FAIL len_midrow_give%0d: got %0b required %0b", c, give_me_only, (c == 3)); end
      end
      you_can_read = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
         if (decoder_read_now) begin
            n_checks++; if (result !== exp_v[got]) begin n_fail++; $display("FAIL len_result%0d: got %0h required %0h", got, result, exp_v[got]); end
            got++;
         end
         @(negedge clk);
      end
      n_checks++; if (got != 2) begin n_fail++; $display("FAIL len_count: got %0d results required 2", got); end
   endtask

   task automatic test_reset_mid_row();
      logic [VW-1:0] av, pv;
      logic [AW-1:0] exp_v;
      int got;
      you_can_read = 1'b0;
      send_chunk(rand_vec(), rand_vec(), 32'd1, 1'b0);
      repeat (6) @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b1) begin n_fail++; $display("FAIL rst_queued: got %0b required 1", decoder_read_now); end
      send_chunk(rand_vec(), rand_vec(), 32'd3, 1'b0);
      send_chunk(rand_vec(), rand_vec(), 32'd3, 1'b0);
      reset = 1'b0;
      #1;
      n_checks++; if (prepare_my_new_input !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %0b required 1", prepare_my_new_input); end
      n_checks++; if (give_me_only !== 1'b0) begin n_fail++; $display("FAIL rst_mid_give: got %0b required 0", give_me_only); end
      n_checks++; if (decoder_read_now !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b required 0", decoder_read_now); end
      n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result: got %0h required 0", result); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      av = rand_vec(); pv = rand_vec();
      exp_v = model_chunk(av, pv, 1'b1);
      send_chunk(av, pv, 32'd1, 1'b1);
      you_can_read = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (decoder_read_now) begin
            n_checks++; if (result !== exp_v) begin n_fail++; $display("FAIL rst_fresh_result: got %0h required %0h", result, exp_v); end
            got++;
         end
         @(negedge clk);
      end
      n_checks++; if (got != 1) begin n_fail++; $display("FAIL rst_fresh_count: got %0d results required 1", got); end
   endtask

   task automatic test_simul_pop_write();
      logic [VW-1:0] av0, pv0, av1, pv1;
      logic [AW-1:0] exp0, exp1;
      av0 = rand_vec(); pv0 = rand_vec(); exp0 = model_chunk(av0, pv0, 1'b0);
      av1 = rand_vec(); pv1 = rand_vec(); exp1 = model_chunk(av1, pv1, 1'b1);
      you_can_read = 1'b0;
      send_chunk(av0, pv0, 32'd1, 1'b0);
      repeat (6) @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b1 || result !== exp0) begin n_fail++; $display("FAIL simul_first: valid %0b result %0h required 1 / %0h", decoder_read_now, result, exp0); end
      send_chunk(av1, pv1, 32'd1, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b1 || result !== exp0) begin n_fail++; $display("FAIL simul_hold: valid %0b result %0h required 1 / %0h", decoder_read_now, result, exp0); end
      you_can_read = 1'b1;
      @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %0b required 1", decoder_read_now); end
      n_checks++; if (result !== exp1) begin n_fail++; $display("FAIL simul_new: got %0h required %0h", result, exp1); end
      @(negedge clk);
      n_checks++; if (decoder_read_now !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %0b required 0", decoder_read_now); end
   endtask

   task automatic test_random();
      localparam int NROWS = 40;
      logic [AW-1:0] q [$];
      int got;
      got = 0;
      fork
         begin
            for (int r = 0; r < NROWS; r++) begin
               int unsigned nm, len;
               logic s;
               logic [VW-1:0] av, pv;
               logic [AW-1:0] sum;
               nm  = $urandom_range(0, 4);
               len = (nm == 0) ? 1 : nm;
               s   = 1'($urandom_range(0, 1));
               sum = '0;
               for (int c = 0; c < int'(len); c++) begin
                  av = rand_vec(); pv = rand_vec();
                  sum = sum + model_chunk(av, pv, s);
                  send_chunk(av, pv, (c == 0) ? nm : $urandom_range(0, 7), s);
               end
               q.push_back(sum);
               if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
         end
         begin
            for (int cyc = 0; cyc < 4000 && got < NROWS; cyc++) begin
               you_can_read = 1'($urandom_range(0, 1));
               if (decoder_read_now && you_can_read) begin
                  n_checks++;
                  if (q.size() == 0) begin
                     n_fail++; $display("FAIL rand_unexpected: result %0h with no row outstanding", result);
                  end else if (result !== q[0]) begin
                     n_fail++; $display("FAIL rand_result%0d: got %0h required %0h", got, result, q[0]);
                     void'(q.pop_front());
                  end else begin
                     void'(q.pop_front());
                  end
                  got++;
               end
               @(negedge clk);
            end
         end
      join
      n_checks++; if (got != NROWS) begin n_fail++; $display("FAIL rand_count: got %0d results required %0d", got, NROWS); end
      you_can_read = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_chunk();
      test_signed_multi();
      test_back_pressure();
      test_length_rules();
      test_reset_mid_row();
      test_simul_pop_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
